// File: rtl/lif_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed LIF neuron datapath.
// Holds the scheduler state encoding and the width rules for the leak product and saturating sum.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } lif_state_t;

    // Ceiling log2 that gives 0 for an argument of 1. Usable in constant expressions.
    function automatic int lif_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One extra bit beyond W+clog2(NUM), so the pot*NUM product can never wrap.
    function automatic int leak_prod_w(input int w, input int num);
        return w + lif_clog2(num) + 1;
    endfunction

    // One carry bit above the potential width, for detecting saturation.
    function automatic int sat_sum_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational binary LIF update for one neuron: leak, integrate one input bit, threshold and reset.
// Pure function of its inputs, so it can be replicated for parallel neuron arrays.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int W          = 8,
    parameter int LAMBDA_NUM = 8,
    parameter int LAMBDA_DEN = 10,
    parameter int THRESH     = 20,
    parameter int RESET_VAL  = 0
) (
    input  logic [W-1:0] pot,
    input  logic         in_bit,
    output logic [W-1:0] next_pot,
    output logic         spike
);

    localparam int PW = leak_prod_w(W, LAMBDA_NUM);
    localparam int SW = sat_sum_w(W);

    logic [PW-1:0] product;
    logic [W-1:0]  leak;
    logic [SW-1:0] sum;
    logic [W-1:0]  integrated;

    // Integer division floors. The quotient never exceeds pot, so it fits back into W bits.
    assign product    = PW'(pot) * PW'(LAMBDA_NUM);
    assign leak       = W'(product / PW'(LAMBDA_DEN));
    assign sum        = SW'(leak) + SW'(in_bit);
    assign integrated = sum[W] ? {W{1'b1}} : sum[W-1:0];

    assign spike    = (integrated >= W'(THRESH));
    assign next_pot = spike ? W'(RESET_VAL) : integrated;

endmodule

// File: rtl/lif_timestep_scheduler.sv
// Shares one LIF update unit across N_NEURONS neurons, visiting one neuron per cycle per timestep.
// Potentials live in a flop array that is read and written at the same index each RUN cycle.
module lif_timestep_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 16,
    parameter int W          = 8,
    parameter int FRAC_BITS  = 5,
    parameter int LAMBDA_NUM = 8,
    parameter int LAMBDA_DEN = 10,
    parameter int THRESH     = 20,
    parameter int RESET_VAL  = 0,
    parameter int STEP_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 start,
    input  logic [N_NEURONS-1:0] in_spikes,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] out_spikes,
    output logic [STEP_W-1:0]    step_count,
    output lif_state_t           dbg_state
);

    // Handshake: start is a one-sided request taken only in IDLE (clear has priority there); it is
    // dropped, never queued, in any other state. done is a one-cycle strobe: out_spikes/step_count
    // change in the same cycle done rises and hold until the next done.

    localparam int IDX_W = (N_NEURONS > 1) ? lif_clog2(N_NEURONS) : 1;

    // FRAC_BITS only documents where the binary point sits; it has no arithmetic effect.
    if (FRAC_BITS > W) begin : g_frac_wider_than_pot
    end

    lif_state_t           state_q;
    lif_state_t           state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [N_NEURONS-1:0] in_latched_q;
    logic [N_NEURONS-1:0] spike_acc_q;
    logic [W-1:0]         pot_q [N_NEURONS];

    logic                 accept_start;
    logic                 accept_clear;
    logic                 last_idx;
    logic                 run_en;
    logic                 finish_en;
    logic                 latch_en;
    logic                 clear_en;
    logic [W-1:0]         rd_pot;
    logic                 rd_in_bit;
    logic [W-1:0]         wr_pot;
    logic                 wr_spike;

    assign accept_clear = (state_q == ST_IDLE) && clear;
    assign accept_start = (state_q == ST_IDLE) && start && !clear;
    assign last_idx     = (idx_q == IDX_W'(N_NEURONS - 1));

    assign rd_pot    = pot_q[idx_q];
    assign rd_in_bit = in_latched_q[idx_q];

    lif_update_unit #(
        .W          (W),
        .LAMBDA_NUM (LAMBDA_NUM),
        .LAMBDA_DEN (LAMBDA_DEN),
        .THRESH     (THRESH),
        .RESET_VAL  (RESET_VAL)
    ) u_update (
        .pot      (rd_pot),
        .in_bit   (rd_in_bit),
        .next_pot (wr_pot),
        .spike    (wr_spike)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_start) state_d = ST_RUN;
            ST_RUN:    if (last_idx) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_RUN);
        run_en    = (state_q == ST_RUN);
        finish_en = (state_q == ST_FINISH);
        latch_en  = accept_start;
        clear_en  = accept_clear;
        dbg_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            in_latched_q <= '0;
            spike_acc_q  <= '0;
            out_spikes   <= '0;
            step_count   <= '0;
            done         <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            done <= finish_en;
            if (clear_en) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    pot_q[i] <= '0;
                end
            end
            if (latch_en) begin
                in_latched_q <= in_spikes;
                idx_q        <= '0;
            end
            // Spike and reset land in the same write, so a fired neuron restarts within this timestep.
            if (run_en) begin
                pot_q[idx_q]       <= wr_pot;
                spike_acc_q[idx_q] <= wr_spike;
                if (!last_idx) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (finish_en) begin
                out_spikes <= spike_acc_q;
                step_count <= step_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Bench for lif_timestep_scheduler: a leaky instance (8/10) and a no-leak instance (1/1, 4-bit counter)
// share stimulus and are checked against a per-timestep arithmetic model of the LIF rules.
module tb_lif_timestep_scheduler;
    import lif_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] in_spikes = '0;

    logic         lk_busy, lk_done, nl_busy, nl_done;
    logic [N-1:0] lk_spk, nl_spk;
    logic [15:0]  lk_cnt;
    logic [3:0]   nl_cnt;
    lif_state_t   lk_st, nl_st;

    lif_timestep_scheduler #(.N_NEURONS(N)) dut_lk (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .in_spikes(in_spikes),
        .busy(lk_busy), .done(lk_done), .out_spikes(lk_spk), .step_count(lk_cnt), .dbg_state(lk_st)
    );

    lif_timestep_scheduler #(.N_NEURONS(N), .LAMBDA_NUM(1), .LAMBDA_DEN(1), .STEP_W(4)) dut_nl (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .in_spikes(in_spikes),
        .busy(nl_busy), .done(nl_done), .out_spikes(nl_spk), .step_count(nl_cnt), .dbg_state(nl_st)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    int           pot_m [2][N];
    int           cnt_m = 0;
    logic [N-1:0] exp_lk = '0;
    logic [N-1:0] exp_nl = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) pot_m[k][i] = 0;
    endtask

    task automatic model_reset();
        model_clear();
        cnt_m  = 0;
        exp_lk = '0;
        exp_nl = '0;
    endtask

    // k=0: leak 8/10, k=1: no leak. Threshold 20, reset to 0, saturate at 255.
    task automatic model_step(input logic [N-1:0] in);
        int num, den, v;
        logic [N-1:0] s;
        for (int k = 0; k < 2; k++) begin
            num = (k == 0) ? 8 : 1;
            den = (k == 0) ? 10 : 1;
            s = '0;
            for (int i = 0; i < N; i++) begin
                v = (pot_m[k][i] * num) / den + int'(in[i]);
                if (v > 255) v = 255;
                if (v >= 20) begin
                    s[i] = 1'b1;
                    pot_m[k][i] = 0;
                end else begin
                    pot_m[k][i] = v;
                end
            end
            if (k == 0) exp_lk = s; else exp_nl = s;
        end
        cnt_m++;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy_lk"}, lk_busy, 0);
        chk({tag, "_busy_nl"}, nl_busy, 0);
        chk({tag, "_done_lk"}, lk_done, 0);
        chk({tag, "_done_nl"}, nl_done, 0);
        chk({tag, "_state_lk"}, lk_st, ST_IDLE);
        chk({tag, "_spk_lk"}, lk_spk, exp_lk);
        chk({tag, "_spk_nl"}, nl_spk, exp_nl);
        chk({tag, "_cnt_lk"}, lk_cnt, cnt_m % 65536);
        chk({tag, "_cnt_nl"}, nl_cnt, cnt_m % 16);
    endtask

    // ---------------- driver ----------------
    // One timestep: pulse start, scramble in_spikes (and optionally start/clear) while the DUT works.
    task automatic run_step(input logic [N-1:0] in, input bit noise);
        int m;
        bit seen;
        @(negedge clk);
        in_spikes = in;
        start = 1'b1;
        clear = 1'b0;
        model_step(in);
        @(posedge clk);
        seen = 0;
        m = 0;
        while (!seen && m < 20) begin
            @(negedge clk);
            if (lk_done) begin
                seen = 1;
                start = 1'b0;
                clear = 1'b0;
            end else begin
                chk("busy_lk", lk_busy, (m < N) ? 1 : 0);
                chk("busy_nl", nl_busy, (m < N) ? 1 : 0);
                chk("done_nl_early", nl_done, 0);
                in_spikes = N'($urandom);
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                clear = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                m++;
            end
        end
        chk("latency", m, N + 1);
        chk("done_nl", nl_done, 1);
        chk("done_busy_overlap", lk_busy | nl_busy, 0);
        chk("spk_lk", lk_spk, exp_lk);
        chk("spk_nl", nl_spk, exp_nl);
        chk("cnt_lk", lk_cnt, cnt_m % 65536);
        chk("cnt_nl", nl_cnt, cnt_m % 16);
        @(negedge clk);
        chk("done_pulse_lk", lk_done, 0);
        chk("done_pulse_nl", nl_done, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           do_clear;
        logic [N-1:0] in;
        int           reps;
        bit           noise;
        logic [N-1:0] exp_lk;
        logic [N-1:0] exp_nl;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int seen, cyc, last;

        tbl[0] = '{1, 4'b0101, 19, 0, 4'b0000, 4'b0000};
        tbl[1] = '{0, 4'b0101,  1, 0, 4'b0000, 4'b0101};
        tbl[2] = '{0, 4'b0101,  1, 1, 4'b0000, 4'b0000};
        tbl[3] = '{1, 4'b1111, 19, 0, 4'b0000, 4'b0000};
        tbl[4] = '{0, 4'b1111,  1, 0, 4'b0000, 4'b1111};
        tbl[5] = '{0, 4'b1111, 80, 1, 4'b0000, 4'b1111};

        model_reset();

        // Reset held 3 cycles, then 10 idle cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_idle("reset_idle");
            @(negedge clk);
        end

        // First timestep with zero input: latency, no spikes, count 1.
        run_step(4'b0000, 0);

        for (int t = 0; t < 6; t++) begin
            if (tbl[t].do_clear) begin
                @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                model_clear();
            end
            for (int r = 0; r < tbl[t].reps; r++) begin
                run_step(tbl[t].in, tbl[t].noise);
            end
            chk($sformatf("tbl%0d_lk", t), lk_spk, tbl[t].exp_lk);
            chk($sformatf("tbl%0d_nl", t), nl_spk, tbl[t].exp_nl);
        end

        // clear+start together in IDLE: clear wins, no timestep runs.
        repeat (5) run_step(4'b1111, 0);
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        in_spikes = 4'b1111;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        model_clear();
        for (int c = 0; c < N + 3; c++) begin
            check_idle("clr_start");
            @(negedge clk);
        end
        repeat (19) run_step(4'b1111, 0);
        chk("post_clear_19_nl", nl_spk, 4'b0000);
        run_step(4'b1111, 0);
        chk("post_clear_20_nl", nl_spk, 4'b1111);

        // Reset while neuron 2 is being processed: no done, everything back to zero.
        repeat (7) run_step(4'b1111, 0);
        @(negedge clk);
        in_spikes = 4'b1111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy", lk_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < N + 3; c++) begin
            check_idle("midrun_rst");
            @(negedge clk);
        end
        run_step(4'b1010, 0);

        // Start held high: one timestep every N+2 cycles.
        model_step('0);
        model_step('0);
        model_step('0);
        @(negedge clk);
        in_spikes = '0;
        start = 1'b1;
        seen = 0;
        cyc = 0;
        last = -1;
        while (seen < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (lk_done) begin
                seen++;
                if (last >= 0) chk("b2b_period", cyc - last, N + 2);
                last = cyc;
            end
            if (seen == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b_count", seen, 3);
        chk("b2b_cnt_lk", lk_cnt, cnt_m % 65536);
        chk("b2b_cnt_nl", nl_cnt, cnt_m % 16);
        @(negedge clk);
        check_idle("b2b_after");

        // Randomized timesteps, noisy controls and occasional clears.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                clear = 1'b1;
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                clear = 1'b0;
                start = 1'b0;
                model_clear();
                check_idle("rand_clear");
            end else begin
                run_step(N'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
